// File: rtl/mag_seq.sv
// mag_seq: multi-cycle magnitude comparator.
// Operands are latched on an accepted start and compared one CHUNK-wide slice
// per clock, most significant slice first. The compare stops at the first
// unequal slice. In two's-complement mode the operands are sign-extended and
// the top bit is flipped, so an unsigned compare gives the signed ordering.
// Results are registered. They change only in the cycle where done pulses.

module mag_seq #(
    parameter int WIDTH  = 12,
    parameter int CHUNK  = 4,
    parameter int SIGNED = 0
) (
    input  logic             sys_clk,
    input  logic             resetl,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             agb,
    output logic             aeb,
    output logic             alb
);

    // Number of slices, padded operand width and slice-index width
    localparam int NCH = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int PW  = NCH * CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [IW-1:0] IDX_TOP  = IW'(NCH - 1);
    localparam logic [IW-1:0] IDX_ZERO = IW'(0);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    // One-hot result encoding {agb, aeb, alb}
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Widen an operand to the padded width.
    // Unsigned: the padding is zero. Signed: the padding repeats the sign bit,
    // and the top bit is flipped. The flip moves negative values below
    // positive ones in unsigned order.
    function automatic logic [PW-1:0] pad_operand(input logic [WIDTH-1:0] x);
        logic [PW-1:0] v;
        v = PW'(x);
        for (int i = WIDTH; i < PW; i++) begin
            if (SIGNED != 0) begin
                v[i] = x[WIDTH-1];
            end else begin
                v[i] = 1'b0;
            end
        end
        if (SIGNED != 0) begin
            v[PW-1] = ~v[PW-1];
        end else begin
            v[PW-1] = v[PW-1];
        end
        return v;
    endfunction

    // Select slice idx (slice 0 is least significant) of a padded operand
    function automatic logic [CHUNK-1:0] get_chunk(input logic [PW-1:0] v,
                                                   input logic [IW-1:0] idx);
        logic [PW-1:0] sh;
        sh = v >> (32'(idx) * CHUNK);
        return sh[CHUNK-1:0];
    endfunction

    // State and datapath registers
    state_t          r_state;
    logic [PW-1:0]   r_a;
    logic [PW-1:0]   r_b;
    logic [IW-1:0]   r_idx;
    logic            r_busy;
    logic            r_done;
    logic [2:0]      r_res;

    // Next-state values from the combinational process
    state_t          w_state_nxt;
    logic            w_load;
    logic [IW-1:0]   w_idx_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic [2:0]      w_res_nxt;
    logic [CHUNK-1:0] w_chunk_a;
    logic [CHUNK-1:0] w_chunk_b;

    assign w_chunk_a = get_chunk(r_a, r_idx);
    assign w_chunk_b = get_chunk(r_b, r_idx);

    // Next-state logic: accept a request, step through slices, finish on the first difference
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_idx_nxt   = r_idx;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_res_nxt   = r_res;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_idx_nxt   = IDX_TOP;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_chunk_a > w_chunk_b) begin
                    w_res_nxt   = RES_GT;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (w_chunk_a < w_chunk_b) begin
                    w_res_nxt   = RES_LT;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (r_idx == IDX_ZERO) begin
                    w_res_nxt   = RES_EQ;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_idx_nxt   = r_idx - IDX_ONE;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, slice index and registered handshake/result outputs
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            r_a    <= '0;
            r_b    <= '0;
            r_idx  <= IDX_ZERO;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_res  <= RES_NONE;
        end else begin
            if (w_load) begin
                r_a <= pad_operand(a);
                r_b <= pad_operand(b);
            end
            r_idx  <= w_idx_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            r_res  <= w_res_nxt;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign agb  = r_res[2];
    assign aeb  = r_res[1];
    assign alb  = r_res[0];

endmodule

// mag_seq_chk: handshake and result-encoding properties of mag_seq
module mag_seq_chk (
    input logic clk,
    input logic rst_n,
    input logic busy,
    input logic done,
    input logic agb,
    input logic aeb,
    input logic alb
);

    // A finished compare carries exactly one result flag
    a_done_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        done |-> $onehot({agb, aeb, alb}));

    // busy has already dropped when done pulses
    a_done_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
        done |-> !busy);

    // done is a single-cycle pulse
    a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        done |=> !done);

endmodule

// File: tb/tb_mag_seq.sv
// tb_mag_seq: scoreboard bench for mag_seq. It instantiates several
// WIDTH/CHUNK/SIGNED configurations. The driver pushes the expected result and
// latency for each accepted request. A separate monitor pops and compares an
// entry on every done. Between done pulses the monitor checks that the
// outputs hold their previous value.

module tb_mag_seq;

    localparam int NI = 6;
    localparam int WK [NI] = '{12, 12, 11, 11, 11, 11};
    localparam int CK [NI] = '{4, 4, 4, 3, 1, 11};
    localparam int SK [NI] = '{0, 1, 0, 1, 0, 1};

    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] LT = 3'b001;

    typedef struct {
        int         k;
        logic [2:0] res;
        int         m;
        longint     t_acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetl;
    logic        start_v [NI];
    logic [11:0] a_v     [NI];
    logic [11:0] b_v     [NI];
    logic        busy_v  [NI];
    logic        done_v  [NI];
    logic        agb_v   [NI];
    logic        aeb_v   [NI];
    logic        alb_v   [NI];

    exp_t        sb [$];
    logic [2:0]  last_res [NI];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mag_seq #(.WIDTH(WK[g]), .CHUNK(CK[g]), .SIGNED(SK[g])) u_dut (
            .sys_clk (clk),
            .resetl  (resetl),
            .start   (start_v[g]),
            .a       (a_v[g][WK[g]-1:0]),
            .b       (b_v[g][WK[g]-1:0]),
            .busy    (busy_v[g]),
            .done    (done_v[g]),
            .agb     (agb_v[g]),
            .aeb     (aeb_v[g]),
            .alb     (alb_v[g])
        );
        mag_seq_chk u_chk (
            .clk   (clk),
            .rst_n (resetl),
            .busy  (busy_v[g]),
            .done  (done_v[g]),
            .agb   (agb_v[g]),
            .aeb   (aeb_v[g]),
            .alb   (alb_v[g])
        );
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Behavioural reference: plain numeric compare of the operands
    function automatic logic [2:0] model(input int k, input logic [11:0] av, input logic [11:0] bv);
        longint x;
        longint y;
        longint one;
        int     w;
        one = 1;
        w = WK[k];
        x = longint'(av);
        y = longint'(bv);
        if (SK[k] != 0 && av[w-1]) x = x - (one << w);
        if (SK[k] != 0 && bv[w-1]) y = y - (one << w);
        if (x > y) return GT;
        if (x < y) return LT;
        return EQ;
    endfunction

    // Slices examined: from the top down to the slice holding the highest differing padded bit
    function automatic int lat(input int k, input logic [11:0] av, input logic [11:0] bv);
        int          w;
        int          c;
        int          nch;
        int          p;
        logic [15:0] pa;
        logic [15:0] pb;
        w = WK[k];
        c = CK[k];
        nch = (w + c - 1) / c;
        pa = '0;
        pb = '0;
        for (int i = 0; i < nch * c; i++) begin
            pa[i] = (i < w) ? av[i] : ((SK[k] != 0) ? av[w-1] : 1'b0);
            pb[i] = (i < w) ? bv[i] : ((SK[k] != 0) ? bv[w-1] : 1'b0);
        end
        p = -1;
        for (int i = 0; i < 16; i++) begin
            if (pa[i] != pb[i]) p = i;
        end
        if (p < 0) return nch;
        return nch - (p / c);
    endfunction

    // Monitor: pop and compare on done, otherwise require the previous result to hold
    always @(negedge clk) begin
        exp_t       e;
        logic [2:0] got;
        for (int k = 0; k < NI; k++) begin
            got = {agb_v[k], aeb_v[k], alb_v[k]};
            if (!resetl) last_res[k] = 3'b000;
            if (done_v[k]) begin
                check($sformatf("busy_at_done_k%0d", k), 32'(busy_v[k]), 32'd0);
                if (sb.size() == 0) begin
                    check($sformatf("unexpected_done_k%0d", k), 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("done_instance_k%0d", k), 32'(k), 32'(e.k));
                    check($sformatf("result_k%0d", k), 32'(got), 32'(e.res));
                    check($sformatf("latency_k%0d", k), 32'($time - e.t_acc), 32'(10 * e.m + 5));
                    last_res[k] = e.res;
                end
            end else begin
                check($sformatf("hold_k%0d", k), 32'(got), 32'(last_res[k]));
            end
        end
    end

    // Wait for done on instance k. mode 1 pokes start with fresh operands on busy cycles.
    // With hold set, start stays high through the done cycle.
    task automatic wait_done(input int k, input int mode, input bit hold);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (n == 0) check($sformatf("busy_after_accept_k%0d", k), 32'(busy_v[k]), 32'd1);
            if (done_v[k]) begin
                found = 1'b1;
                start_v[k] = hold;
                break;
            end else if (mode == 1 && busy_v[k]) begin
                start_v[k] = 1'b1;
                a_v[k] = 12'($urandom);
                b_v[k] = 12'($urandom);
            end else begin
                start_v[k] = 1'b0;
            end
        end
        if (!found) begin
            check($sformatf("done_timeout_k%0d", k), 32'd0, 32'd1);
            start_v[k] = 1'b0;
            if (sb.size() > 0) void'(sb.pop_back());
        end
    endtask

    task automatic run_op(input int k, input logic [11:0] av, input logic [11:0] bv,
                          input logic [2:0] res, input int m, input int mode,
                          input bit fresh, input bit hold);
        exp_t e;
        if (fresh) @(negedge clk);
        a_v[k] = av;
        b_v[k] = bv;
        start_v[k] = 1'b1;
        @(posedge clk);
        e.k = k;
        e.res = res;
        e.m = m;
        e.t_acc = longint'($time);
        sb.push_back(e);
        wait_done(k, mode, hold);
    endtask

    initial begin
        logic [11:0] msk;
        logic [11:0] av;
        logic [11:0] bv;
        resetl = 1'b0;
        for (int k = 0; k < NI; k++) begin
            start_v[k] = 1'b0;
            a_v[k] = 12'h000;
            b_v[k] = 12'h000;
        end
        #12;
        for (int k = 0; k < NI; k++)
            check($sformatf("reset_state_k%0d", k),
                  32'({busy_v[k], done_v[k], agb_v[k], aeb_v[k], alb_v[k]}), 32'd0);
        @(negedge clk);
        resetl = 1'b1;

        // Directed vectors
        run_op(0, 12'h800, 12'h7FF, GT, 1, 0, 1'b1, 1'b0);
        run_op(1, 12'h800, 12'h7FF, LT, 1, 0, 1'b1, 1'b0);
        run_op(1, 12'hFFF, 12'h000, LT, 1, 0, 1'b1, 1'b0);
        run_op(0, 12'h5A5, 12'h5A5, EQ, 3, 0, 1'b1, 1'b0);
        run_op(0, 12'h123, 12'h124, LT, 3, 0, 1'b1, 1'b0);
        run_op(2, 12'h7FF, 12'h000, GT, 1, 0, 1'b1, 1'b0);
        run_op(2, 12'h400, 12'h3FF, GT, 1, 0, 1'b1, 1'b0);
        run_op(3, 12'h001, 12'h002, LT, 4, 0, 1'b1, 1'b0);
        run_op(4, 12'h400, 12'h000, GT, 1, 0, 1'b1, 1'b0);
        run_op(4, 12'h001, 12'h000, GT, 11, 0, 1'b1, 1'b0);
        run_op(5, 12'h7FF, 12'h000, LT, 1, 0, 1'b1, 1'b0);
        run_op(5, 12'h3FF, 12'h400, GT, 1, 0, 1'b1, 1'b0);

        // start pokes with other operands while busy must not disturb the result
        run_op(0, 12'h5A5, 12'h5A4, GT, 3, 1, 1'b1, 1'b0);
        run_op(3, 12'h000, 12'h000, EQ, 4, 1, 1'b1, 1'b0);

        // start held high: a new accept on the edge after each done
        run_op(0, 12'h100, 12'h0FF, GT, 1, 0, 1'b1, 1'b1);
        run_op(0, 12'h0FF, 12'h100, LT, 1, 0, 1'b0, 1'b1);
        run_op(0, 12'h123, 12'h123, EQ, 3, 0, 1'b0, 1'b1);
        run_op(0, 12'h120, 12'h121, LT, 3, 0, 1'b0, 1'b1);
        run_op(0, 12'h0A0, 12'h0B0, LT, 2, 0, 1'b0, 1'b0);

        // Reset between edges during the second slice of a three-slice compare
        run_op(0, 12'h0F0, 12'h00F, GT, 2, 0, 1'b1, 1'b0);
        @(negedge clk);
        a_v[0] = 12'h5A5;
        b_v[0] = 12'h5A5;
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        @(posedge clk);
        #3;
        resetl = 1'b0;
        #1;
        check("async_reset_outputs",
              32'({busy_v[0], done_v[0], agb_v[0], aeb_v[0], alb_v[0]}), 32'd0);
        repeat (2) @(negedge clk);
        resetl = 1'b1;
        run_op(0, 12'h001, 12'h001, EQ, 3, 0, 1'b1, 1'b0);

        // Random pairs against the behavioural model
        for (int k = 0; k < NI; k++) begin
            msk = 12'((1 << WK[k]) - 1);
            for (int i = 0; i < 150; i++) begin
                av = 12'($urandom) & msk;
                bv = 12'($urandom) & msk;
                if (i % 8 == 0) bv = av;
                if (i % 8 == 1) bv = av ^ 12'h001;
                run_op(k, av, bv, model(k, av, bv), lat(k, av, bv), 0, 1'b1, 1'b0);
            end
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mag_seq.md
# mag_seq

Parametrised, multi-cycle magnitude comparator for the Tom/Jerry datapath. It is the sequential successor of the fixed-width combinational comparators (11/12-bit) used by the object processor and blitter. Operands are captured on a start strobe and compared MSB-chunk first, CHUNK bits per cycle, with early termination on the first unequal chunk. It supports unsigned or two's-complement mode and gives a start/busy/done handshake so wide compares never sit on a single-cycle critical path.

## Interface
Parameters:
- WIDTH, 12: operand width in bits (≥1).
- CHUNK, 4: bits compared per cycle (1..WIDTH).
- SIGNED, 0: 0 = unsigned compare, 1 = two's-complement compare.

Derived: NCH = ceil(WIDTH/CHUNK); PW = NCH*CHUNK (padded width).

Ports:
- sys_clk, in, 1: system clock; all state changes on rising edge.
- resetl, in, 1: asynchronous, active-low reset.
- start, in, 1: request; sampled on a rising edge only when busy=0.
- a, in, WIDTH: operand A; captured on an accepted start.
- b, in, WIDTH: operand B; captured on an accepted start.
- busy, out, 1: compare in progress.
- done, out, 1: one-cycle pulse; result outputs valid and updated.
- agb, out, 1: A > B (registered).
- aeb, out, 1: A == B (registered).
- alb, out, 1: A < B (registered).

## Operation
- Reset (resetl=0, asynchronous, any state):
  - busy=0, done=0, agb=0, aeb=0, alb=0.
  - FSM goes to IDLE; chunk index and operand registers are cleared.
- Operand capture on accept:
  - Unsigned: zero-extend a and b to PW.
  - Signed: sign-extend a and b to PW, then invert bit PW-1 of both. This maps signed order onto unsigned order.
- FSM IDLE:
  - start=1 accepts the request: latch operands, set idx=NCH-1, busy=1, go RUN.
  - start=0: hold.
- FSM RUN, each edge: compare padded chunk idx of A against the same chunk of B as unsigned values.
  - Chunk A > chunk B: agb=1, aeb=0, alb=0, done=1, busy=0, go IDLE.
  - Chunk A < chunk B: alb=1, others 0, done=1, busy=0, go IDLE.
  - Chunks equal and idx=0: aeb=1, others 0, done=1, busy=0, go IDLE.
  - Chunks equal and idx>0: idx=idx-1, stay RUN.
- Output rules:
  - agb/aeb/alb keep the last result until the next done. During busy they show the previous result, not an intermediate one.
  - Exactly one of agb/aeb/alb is 1 after the first done. All are 0 only between reset and the first done.
- start while busy=1 is ignored. It is not queued and does not disturb the operation in progress.
- a/b changes after capture have no effect.

## Timing
- Latency: done is asserted m edges after the accepting edge, where m is the number of chunks examined (1 ≤ m ≤ NCH).
- done is high for exactly one cycle, in the same cycle the new result first appears.
- busy rises the cycle after the accepting edge. It falls in the same cycle done rises.
- Back-to-back operation: start held high during the done cycle is accepted at the next edge, so the sustained issue rate is one compare per m+1 cycles.
- CHUNK=WIDTH gives a fixed latency of 1.
- Reset asserted mid-RUN aborts immediately: no done pulse, outputs go to reset values. After resetl is released, the first start behaves as from power-up.

## Test plan
- WIDTH=12, CHUNK=4, SIGNED=0: a=0x800, b=0x7FF. Required: done one edge after accept, agb=1, busy high for 1 cycle.
- Same configuration, SIGNED=1: a=0x800 (-2048), b=0x7FF. Required: alb=1 after 1 edge. Also a=0xFFF (-1), b=0x000: alb=1 after 1 edge.
- WIDTH=12, CHUNK=4: a=b=0x5A5, aeb=1 after 3 edges. Then a=0x123, b=0x124: alb=1 after 3 edges. During the second op, outputs hold aeb=1 until its done.
- WIDTH=11, CHUNK=4 (padding case): a=0x7FF, b=0x000 gives agb after 1 edge. a=0x400, b=0x3FF gives agb after 1 edge. Check all three outputs against a behavioural a>b / a==b / a<b model over 10k random pairs for every SIGNED/CHUNK ∈ {1,3,4,11} combination.
- Handshake: pulse start again on each busy cycle with different operands. Required: no effect on the result. Hold start high continuously. Required: a new accept on the edge following each done, with a period of m+1 cycles.
- Reset: assert resetl=0 asynchronously between edges during the second chunk of a 3-chunk compare. Required: busy/done/agb/aeb/alb drop to 0 immediately, with no done pulse. A following start of 0x001 vs 0x001 returns aeb=1 after 3 edges.
